// File: rtl/sys_ctrl.sv
// Command-frame decoder for the UART link: sequences register file writes/reads,
// ALU operations and pushes of read data / ALU results into the TX FIFO.
module sys_ctrl #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [BUS_WIDTH-1:0]   RX_P_DATA,
  input  logic                   RX_D_VLD,
  input  logic [BUS_WIDTH-1:0]   RdData,
  input  logic                   RdData_Valid,
  input  logic [2*BUS_WIDTH-1:0] ALU_OUT,
  input  logic                   OUT_Valid,
  input  logic                   FIFO_FULL,
  output logic                   WrEn,
  output logic                   RdEn,
  output logic [ADDR_WIDTH-1:0]  Address,
  output logic [BUS_WIDTH-1:0]   WrData,
  output logic                   ALU_EN,
  output logic [FUN_WIDTH-1:0]   ALU_FUN,
  output logic                   CLK_EN,
  output logic [BUS_WIDTH-1:0]   TX_P_DATA,
  output logic                   TX_D_VLD
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] TX_RD    = 4'd5;
  localparam logic [3:0] ALU_A    = 4'd6;
  localparam logic [3:0] ALU_B    = 4'd7;
  localparam logic [3:0] ALU_FN   = 4'd8;
  localparam logic [3:0] ALU_WAIT = 4'd9;
  localparam logic [3:0] TX_LSB   = 4'd10;
  localparam logic [3:0] TX_MSB   = 4'd11;

  localparam logic [BUS_WIDTH-1:0] CMD_WR     = BUS_WIDTH'(8'hAA);
  localparam logic [BUS_WIDTH-1:0] CMD_RD     = BUS_WIDTH'(8'hBB);
  localparam logic [BUS_WIDTH-1:0] CMD_ALU_OP = BUS_WIDTH'(8'hCC);
  localparam logic [BUS_WIDTH-1:0] CMD_ALU_NP = BUS_WIDTH'(8'hDD);

  logic [3:0]            state_q, state_d;
  logic [BUS_WIDTH-1:0]  alu_msb_q, alu_msb_d;
  logic                  wr_en_d, rd_en_d, alu_en_d, clk_en_d, tx_vld_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [BUS_WIDTH-1:0]  wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_d;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      alu_msb_q <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      ALU_EN    <= 1'b0;
      CLK_EN    <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      ALU_FUN   <= '0;
      TX_P_DATA <= '0;
    end else begin
      state_q   <= state_d;
      alu_msb_q <= alu_msb_d;
      WrEn      <= wr_en_d;
      RdEn      <= rd_en_d;
      ALU_EN    <= alu_en_d;
      CLK_EN    <= clk_en_d;
      TX_D_VLD  <= tx_vld_d;
      Address   <= addr_d;
      WrData    <= wr_data_d;
      ALU_FUN   <= alu_fun_d;
      TX_P_DATA <= tx_data_d;
    end
  end

  // Next state and next output values; strobes default low, data holds
  always_comb begin
    state_d   = state_q;
    alu_msb_d = alu_msb_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    addr_d    = Address;
    wr_data_d = WrData;
    alu_fun_d = ALU_FUN;
    tx_data_d = TX_P_DATA;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:     state_d = WR_ADDR;
            CMD_RD:     state_d = RD_ADDR;
            CMD_ALU_OP: state_d = ALU_A;
            CMD_ALU_NP: state_d = ALU_FN;
            default:    state_d = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          tx_data_d = RdData;
          tx_vld_d  = !FIFO_FULL;
          state_d   = TX_RD;
        end
      end
      // A TX state leaves once its push is on the bus; otherwise it retries while not full
      TX_RD: begin
        if (TX_D_VLD) state_d = IDLE;
        else          tx_vld_d = !FIFO_FULL;
      end
      ALU_A: begin
        if (RX_D_VLD) begin
          addr_d    = '0;
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ALU_B;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ALU_FN;
        end
      end
      ALU_FN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (OUT_Valid) begin
          tx_data_d = ALU_OUT[BUS_WIDTH-1:0];
          alu_msb_d = ALU_OUT[2*BUS_WIDTH-1:BUS_WIDTH];
          tx_vld_d  = !FIFO_FULL;
          state_d   = TX_LSB;
        end
      end
      TX_LSB: begin
        if (TX_D_VLD) begin
          tx_data_d = alu_msb_q;
          tx_vld_d  = !FIFO_FULL;
          state_d   = TX_MSB;
        end else begin
          tx_vld_d = !FIFO_FULL;
        end
      end
      TX_MSB: begin
        if (TX_D_VLD) state_d = IDLE;
        else          tx_vld_d = !FIFO_FULL;
      end
      default: state_d = IDLE;
    endcase

    // ALU clock runs from operand load until the result has been sampled
    clk_en_d = (state_d == ALU_A) || (state_d == ALU_B) ||
               (state_d == ALU_FN) || (state_d == ALU_WAIT);
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: behavioural register file / ALU around the DUT, a frame-level
// expectation model, and a per-cycle monitor comparing strobes and TX pushes.
module tb_sys_ctrl;
  localparam int unsigned BW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned FW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [BW-1:0]   RX_P_DATA = '0;
  logic            RX_D_VLD = 1'b0;
  logic [BW-1:0]   RdData = '0;
  logic            RdData_Valid = 1'b0;
  logic [2*BW-1:0] ALU_OUT = '0;
  logic            OUT_Valid = 1'b0;
  logic            FIFO_FULL = 1'b0;
  logic            WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [AW-1:0]   Address;
  logic [BW-1:0]   WrData, TX_P_DATA;
  logic [FW-1:0]   ALU_FUN;

  always #5 CLK = ~CLK;

  sys_ctrl #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [3:0] fn, input logic [7:0] a,
                                            input logic [7:0] b);
    case (fn)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return 16'(a ^ b);
    endcase
  endfunction

  // Environment: register file with one-cycle read latency, ALU with one-cycle result
  logic [BW-1:0] rf_mem [16] = '{default: '0};
  always @(posedge CLK) begin
    RdData_Valid <= RdEn;
    if (RdEn) RdData <= rf_mem[Address];
    if (WrEn) rf_mem[Address] <= WrData;
    OUT_Valid <= ALU_EN;
    if (ALU_EN) ALU_OUT <= alu_model(ALU_FUN, rf_mem[0], rf_mem[1]);
  end

  // Cycle bookkeeping for latency checks
  int cyc = 0, byte_cyc = 0, valid_cyc = 0, tx_since = 0;
  logic full_since = 1'b0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RX_D_VLD) byte_cyc <= cyc + 1;
    if (RdData_Valid || OUT_Valid) begin
      valid_cyc  <= cyc + 1;
      tx_since   <= 0;
      full_since <= FIFO_FULL;
    end else begin
      if (TX_D_VLD) tx_since <= tx_since + 1;
      if (FIFO_FULL) full_since <= 1'b1;
    end
  end

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  logic [7:0] model_rf [16] = '{default: '0};
  wr_t        exp_wr [$];
  logic [3:0] exp_rd [$];
  logic [3:0] exp_fun [$];
  logic [7:0] exp_tx [$];
  logic [7:0] tx_log [$];
  wr_t        mon_w;
  logic [7:0] mon_b;

  // Per-cycle compare of every strobe against the model's expectation queues
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (WrEn) begin
        chk("wr_rd_exclusive", 32'(RdEn), 32'd0);
        chk("wr_latency", 32'(cyc), 32'(byte_cyc));
        if (exp_wr.size() == 0) chk("unexpected_wr", 32'(WrEn), 32'd0);
        else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 32'(Address), 32'(mon_w.a));
          chk("wr_data", 32'(WrData), 32'(mon_w.d));
        end
      end
      if (RdEn) begin
        chk("rd_latency", 32'(cyc), 32'(byte_cyc));
        if (exp_rd.size() == 0) chk("unexpected_rd", 32'(RdEn), 32'd0);
        else chk("rd_addr", 32'(Address), 32'(exp_rd.pop_front()));
      end
      if (ALU_EN) begin
        chk("alu_latency", 32'(cyc), 32'(byte_cyc));
        chk("clk_en_at_alu_en", 32'(CLK_EN), 32'd1);
        if (exp_fun.size() == 0) chk("unexpected_alu", 32'(ALU_EN), 32'd0);
        else chk("alu_fun", 32'(ALU_FUN), 32'(exp_fun.pop_front()));
      end
      if (OUT_Valid) chk("clk_en_at_out_valid", 32'(CLK_EN), 32'd1);
      if (TX_D_VLD) begin
        chk("tx_while_full", 32'(FIFO_FULL), 32'd0);
        if (!full_since) chk("tx_latency", 32'(cyc), 32'(valid_cyc + tx_since));
        tx_log.push_back(TX_P_DATA);
        if (exp_tx.size() == 0) chk("unexpected_tx", 32'(TX_D_VLD), 32'd0);
        else begin
          mon_b = exp_tx.pop_front();
          chk("tx_data", 32'(TX_P_DATA), 32'(mon_b));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr.push_back('{a: a, d: d});
    model_rf[a] = d;
    send_byte(8'hAA); send_byte({4'h0, a}); send_byte(d);
  endtask

  task automatic do_read(input logic [3:0] a);
    exp_rd.push_back(a);
    exp_tx.push_back(model_rf[a]);
    send_byte(8'hBB); send_byte({4'h0, a});
  endtask

  task automatic expect_alu(input logic [3:0] fn);
    logic [15:0] r;
    r = alu_model(fn, model_rf[0], model_rf[1]);
    exp_fun.push_back(fn);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  task automatic do_alu_cc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
    exp_wr.push_back('{a: 4'd0, d: a});
    exp_wr.push_back('{a: 4'd1, d: b});
    model_rf[0] = a;
    model_rf[1] = b;
    expect_alu(fn);
    send_byte(8'hCC); send_byte(a); send_byte(b); send_byte({4'h0, fn});
  endtask

  task automatic do_alu_dd(input logic [3:0] fn);
    expect_alu(fn);
    send_byte(8'hDD); send_byte({4'h0, fn});
  endtask

  function automatic int pending();
    return exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size();
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 60 && pending() != 0; i++) @(negedge CLK);
    chk("frame_done", 32'(pending()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_clk_en"}, 32'(CLK_EN), 32'd0);
    chk({tag, "_strobes"}, 32'({WrEn, RdEn, ALU_EN, TX_D_VLD}), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wren"}, 32'(WrEn), 32'd0);
    chk({tag, "_rden"}, 32'(RdEn), 32'd0);
    chk({tag, "_alu_en"}, 32'(ALU_EN), 32'd0);
    chk({tag, "_clk_en"}, 32'(CLK_EN), 32'd0);
    chk({tag, "_tx_vld"}, 32'(TX_D_VLD), 32'd0);
    chk({tag, "_address"}, 32'(Address), 32'd0);
    chk({tag, "_wrdata"}, 32'(WrData), 32'd0);
    chk({tag, "_alu_fun"}, 32'(ALU_FUN), 32'd0);
    chk({tag, "_tx_data"}, 32'(TX_P_DATA), 32'd0);
  endtask

  initial begin
    #3 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b1;

    // Write then read back through the TX path
    do_write(4'd5, 8'h3C);
    wait_done();
    chk("rf5_readback", 32'(rf_mem[5]), 32'h3C);
    do_read(4'd5);
    wait_done();
    chk("read_tx_count", 32'(tx_log.size()), 32'd1);
    chk("read_tx_byte", 32'(tx_log[0]), 32'h3C);

    // ALU frames: add with operands, multiply (checks byte order), then no-operand add
    check_idle("pre_alu");
    do_alu_cc(8'h0A, 8'h03, 4'd0);
    wait_done();
    check_idle("post_alu");
    chk("add_lsb", 32'(tx_log[1]), 32'h0D);
    chk("add_msb", 32'(tx_log[2]), 32'h00);
    do_alu_cc(8'h10, 8'h20, 4'd2);
    wait_done();
    chk("mul_lsb", 32'(tx_log[3]), 32'h00);
    chk("mul_msb", 32'(tx_log[4]), 32'h02);
    do_alu_dd(4'd0);
    wait_done();
    chk("dd_add_lsb", 32'(tx_log[5]), 32'h30);
    chk("dd_add_msb", 32'(tx_log[6]), 32'h00);

    // Stray bytes in IDLE are ignored
    send_byte(8'h55);
    send_byte(8'h00);
    repeat (4) @(negedge CLK);
    check_idle("stray");
    do_write(4'd2, 8'hFF);
    wait_done();
    chk("rf2_readback", 32'(rf_mem[2]), 32'hFF);

    // Read while the TX FIFO is full: no push until released, then exactly one
    @(negedge CLK) FIFO_FULL = 1'b1;
    do_read(4'd2);
    repeat (10) @(negedge CLK);
    chk("no_tx_while_full", 32'(tx_log.size()), 32'd7);
    FIFO_FULL = 1'b0;
    wait_done();
    chk("full_release_count", 32'(tx_log.size()), 32'd8);
    chk("full_release_byte", 32'(tx_log[7]), 32'hFF);

    // Reset mid-frame aborts the write
    send_byte(8'hAA);
    send_byte(8'h07);
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midframe");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("aborted_write", 32'(rf_mem[7]), 32'h00);
    do_write(4'd7, 8'h11);
    wait_done();
    chk("rf7_readback", 32'(rf_mem[7]), 32'h11);
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
